// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the writeback path.
package rf_pkg;

  localparam int XLEN       = 64;
  localparam int GPR_AW     = 5;
  localparam int NR_GPR     = 32;
  localparam int SB_CNT_W   = 2;
  localparam int SB_CNT_MAX = 3;

  typedef logic [GPR_AW-1:0] gpr_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST_INIT = PW'(N - 1);

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic [PW-1:0] win;
  logic [PW:0]   pos;
  logic          found;

  // Wrapping priority search starting at (last + 1) mod N.
  always_comb begin
    grant = '0;
    win   = last_q;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, last_q} + (PW+1)'(k + 1);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      if (!found && req[pos[PW-1:0]]) begin
        grant[pos[PW-1:0]] = 1'b1;
        win                = pos[PW-1:0];
        found              = 1'b1;
      end
    end
  end

  // Pointer moves to the winner only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance && found) begin
      last_d = win;
    end
  end

  // Pointer register; reset leaves requester 0 as the first winner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= LAST_INIT;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with per-GPR pending-write scoreboard.
// Handshake: a requester transfers in any cycle where req_valid[i] and
// req_ready[i] are both high; ready is never high without valid, and a
// valid requester keeps rd/data stable until it sees ready.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = GPR_AW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_rd,
  output logic                 sb_full,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 flush
);

  localparam int NREG = 2 ** AW;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = SB_CNT_W'(SB_CNT_MAX);

  logic [NREQ-1:0] grant;
  logic            hs;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            rf_wen_q,   rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic [SB_CNT_W-1:0] cnt_q [NREG];
  logic [SB_CNT_W-1:0] cnt_d [NREG];

  rr_arbiter #(.N(NREQ)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (hs),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  // Mux the granted requester's destination and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Next write-port state; writes to x0 complete the handshake but are dropped.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (hs && (sel_rd != '0)) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = sel_rd;
      rf_wdata_d = sel_data;
    end
  end

  // Registered write port, one cycle after the handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Scoreboard update: flush wins, a same-edge set and retire cancel out.
  always_comb begin
    logic inc;
    logic dec;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      inc = sb_set && (sb_set_rd == AW'(r)) && (cnt_q[r] != CNT_MAX);
      dec = rf_wen_q && (rf_waddr_q == AW'(r));
      if (r == 0 || flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  // Pending-write counters, one per GPR; x0 is held at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign sb_full  = (sb_set_rd != '0) && (cnt_q[sb_set_rd] == CNT_MAX);
  assign rs1_busy = (cnt_q[rs1] != '0);
  assign rs2_busy = (cnt_q[rs2] != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed steps then randomized traffic vs. a reference model.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic                 clock;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 sb_set;
  logic [AW-1:0]        sb_set_rd;
  logic                 sb_full;
  logic [AW-1:0]        rs1;
  logic [AW-1:0]        rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 flush;

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_last;
  int              m_cnt [32];
  logic            m_wen;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_wdata;
  int              m_grant;

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sb_set    (sb_set),
    .sb_set_rd (sb_set_rd),
    .sb_full   (sb_full),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .flush     (flush)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_grant = -1;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  // Who wins: first valid requester after the previous winner, wrapping.
  function automatic int model_pick();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    req_rd[i*AW +: AW]     = rd;
    req_data[i*XLEN +: XLEN] = data;
  endtask

  // One clock cycle: inputs already applied after a negedge.
  task automatic step();
    int p;
    logic [NREQ-1:0] exp_ready;
    logic old_wen;
    logic [AW-1:0] old_addr;
    #2;
    p = model_pick();
    exp_ready = '0;
    if (p >= 0) exp_ready[p] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rs1_busy", 64'(rs1_busy), 64'(m_cnt[rs1] != 0));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_cnt[rs2] != 0));
    if (sb_set) chk("sb_full", 64'(sb_full), 64'((sb_set_rd != 0) && (m_cnt[sb_set_rd] == 3)));
    @(posedge clock);
    old_wen  = m_wen;
    old_addr = m_waddr;
    for (int r = 1; r < 32; r++) begin
      bit inc, dec;
      inc = sb_set && (sb_set_rd == r) && (m_cnt[r] < 3);
      dec = old_wen && (old_addr == r);
      if (flush) m_cnt[r] = 0;
      else if (inc && dec) m_cnt[r] = m_cnt[r];
      else if (inc) m_cnt[r] = m_cnt[r] + 1;
      else if (dec && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
    end
    m_grant = p;
    m_wen = 1'b0;
    if (p >= 0) begin
      m_last = p;
      if (req_rd[p*AW +: AW] != 0) begin
        m_wen   = 1'b1;
        m_waddr = req_rd[p*AW +: AW];
        m_wdata = req_data[p*XLEN +: XLEN];
      end
    end
    #1;
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    if (m_wen) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    sb_set    = 1'b0;
    sb_set_rd = '0;
    flush     = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    req_rd    = '0;
    req_data  = '0;
    rs1       = 5'd1;
    rs2       = 5'd2;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_wen", 64'(rf_wen), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", rf_wdata, 64'd0);
    chk("reset_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // rotation with all requesters valid
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 64'h1000 + 64'(i));
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rotation", 64'(req_ready), 64'(1 << (k % 3)));
      step();
    end

    // single write from requester 1, then a write to x0 from requester 0
    req_valid = 3'b010;
    set_req(1, 5'd5, 64'hDEAD_BEEF_0000_0001);
    step();
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdata", rf_wdata, 64'hDEAD_BEEF_0000_0001);
    req_valid = 3'b001;
    set_req(0, 5'd0, 64'h55);
    step();
    chk("x0_no_wen", 64'(rf_wen), 64'd0);

    // hazard timing on x7
    idle_inputs();
    rs1 = 5'd7;
    sb_set = 1'b1; sb_set_rd = 5'd7;
    step();
    sb_set = 1'b0;
    repeat (4) step();
    chk("busy_before_wb", 64'(rs1_busy), 64'd1);
    req_valid = 3'b001; set_req(0, 5'd7, 64'h77);
    step();
    req_valid = '0;
    #1;
    chk("busy_T6", 64'(rs1_busy), 64'd1);
    step();
    chk("clear_T7", 64'(rs1_busy), 64'd0);

    // saturation on x9
    rs2 = 5'd9;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    repeat (3) step();
    chk("sat_full", 64'(sb_full), 64'd1);
    step();
    sb_set = 1'b0;
    // collision: set arrives on the same edge as a retire of x9
    req_valid = 3'b100; set_req(2, 5'd9, 64'h99);
    repeat (2) step();
    req_valid = '0;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    step();
    sb_set = 1'b0;
    repeat (3) step();

    // flush with a write to x3 in flight
    rs1 = 5'd3; rs2 = 5'd4;
    sb_set = 1'b1; sb_set_rd = 5'd3; step();
    sb_set_rd = 5'd4; step();
    sb_set = 1'b0;
    flush = 1'b1;
    req_valid = 3'b001; set_req(0, 5'd3, 64'h3333);
    step();
    flush = 1'b0; req_valid = '0;
    #1;
    chk("flush_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
    chk("flush_wb_addr", 64'(rf_waddr), 64'd3);
    step();
    chk("flush_sat", 64'(rs1_busy), 64'd0);

    // reset mid-run with a write on the port
    sb_set = 1'b1; sb_set_rd = 5'd3; step();
    sb_set = 1'b0;
    req_valid = 3'b010; set_req(1, 5'd12, 64'hABC);
    step();
    req_valid = '0;
    chk("pre_reset_wen", 64'(rf_wen), 64'd1);
    reset = 1'b0;
    #1;
    chk("midreset_wen", 64'(rf_wen), 64'd0);
    chk("midreset_waddr", 64'(rf_waddr), 64'd0);
    chk("midreset_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '1;
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'd1);
    step();

    // randomized traffic; a valid requester holds its payload until granted
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || m_grant == i) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, AW'($urandom_range(0, 31)), {$urandom, $urandom});
        end
      end
      sb_set    = ($urandom_range(0, 99) < 40);
      sb_set_rd = AW'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 99) < 3);
      rs1       = AW'($urandom_range(0, 31));
      rs2       = AW'($urandom_range(0, 31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback requesters, such as the EXU result, the LSU load return and the CSR unit.
- Each requester uses a valid/ready handshake; a round-robin arbiter grants one per cycle.
- The granted write is registered and driven onto the RF write port.
- A per-GPR pending-write scoreboard gives the issue stage rs1/rs2 hazard flags.
- Sits between the execute/memory units and the RF.

Parameters:
- NREQ, 3, number of writeback requesters (2..4)
- XLEN, 64, data width
- AW, 5, GPR address width (32 registers)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  requester i granted this cycle
- req_rd  in  NREQ*AW  destination register, packed, requester 0 in LSBs
- req_data  in  NREQ*XLEN  write data, packed
- rf_wen  out  1  to RF wen
- rf_waddr  out  AW  to RF waddr
- rf_wdata  out  XLEN  to RF wdata
- sb_set  in  1  issue stage dispatches an instruction writing sb_set_rd
- sb_set_rd  in  AW  destination of the dispatched instruction
- sb_full  out  1  pending counter of sb_set_rd is saturated; issue must stall
- rs1  in  AW  issue-stage source 1
- rs2  in  AW  issue-stage source 2
- rs1_busy  out  1  rs1 has an uncommitted pending write
- rs2_busy  out  1  rs2 has an uncommitted pending write
- flush  in  1  pipeline flush; clear the scoreboard

Behaviour:
- Reset (reset=0, asynchronous):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - All scoreboard counters = 0.
  - Combinational outputs follow from this reset state.
- Arbitration (combinational):
  - Search valid requesters starting at (last+1) mod NREQ, wrapping.
  - The first valid one gets req_ready[i]=1; at most one ready bit is high.
  - req_ready never asserts without the matching req_valid.
  - On a handshake, last<=i. With no valid request, last holds.
- Requester rule: a valid requester holds req_rd and req_data stable until ready. The arbiter does not check this.
- Write latency 1:
  - A handshake in cycle T drives rf_wen=1, rf_waddr=rd, rf_wdata=data in cycle T+1.
  - The RF captures the write at the end of T+1.
  - If rd==0, the handshake still completes but rf_wen stays 0.
  - No handshake in T gives rf_wen=0 in T+1; waddr/wdata hold their last values.
  - No back-pressure: one write per cycle is sustained indefinitely.
- Scoreboard:
  - One 2-bit counter per GPR 1..31; x0 is never tracked and always reads 0.
  - Increment: sb_set=1, sb_set_rd!=0 and counter<3.
  - If sb_set with counter==3, sb_full=1 and the set is ignored.
  - sb_full is combinational on sb_set_rd and is 0 when sb_set_rd==0.
  - Decrement: at the clock edge ending a cycle with rf_wen=1, the rf_waddr counter decrements, saturating at 0.
  - Increment and decrement of the same register at the same edge leave it unchanged.
- Hazard flags:
  - rs1_busy = (cnt[rs1]!=0); rs2_busy likewise. Combinational, no bypass.
  - A register stays busy through cycle T+1 and is clear in T+2, when the RF read already returns the new data.
- Flush (synchronous, priority over set and decrement):
  - All counters go to 0 at the next edge.
  - In-flight grants and the registered write still complete; their later decrements saturate at 0.
  - Arbitration is unaffected.
- Simultaneous events: all requesters valid gives strict rotation 0,1,2,0,... with no starvation.

Decomposition:
- Package rf_pkg holds:
  - XLEN=64, GPR_AW=5, NR_GPR=32, SB_CNT_W=2, SB_CNT_MAX=3
  - typedef gpr_addr_t (logic [GPR_AW-1:0])
  - typedef xlen_t (logic [XLEN-1:0])
- Sub-module rr_arbiter (parameter N): inputs req, advance; outputs one-hot grant; owns the pointer.
- The scoreboard counters and the write register stay in rf_wb_arbiter.

Test Plan:
- Reset mid-run: reset low while rf_wen=1 → rf_wen=0, rf_waddr=0 and all busy flags 0 immediately; after release, first grant with all valid is requester 0.
- Rotation: req_valid=3'b111 held 6 cycles → req_ready sequence 001,010,100,001,010,100; rf_waddr follows each requester's rd one cycle later.
- Single write path: requester 1 writes rd=5, data=0xDEAD_BEEF_0000_0001 at T → rf_wen=1, rf_waddr=5, wdata matches at T+1. Requester 0 with rd=0 → ready=1, rf_wen=0 next cycle.
- Scoreboard hazard timing: sb_set rd=7 at T0, rs1=7 → rs1_busy=1 from T0+1; handshake rd=7 at T5 → busy through T6, 0 at T7.
- Saturation and collision:
  - Three sb_set rd=9 → counter 3; fourth sb_set → sb_full=1 and the count stays 3.
  - sb_set rd=9 in the same cycle as rf_wen to 9 → count unchanged.
- Flush: counters for x3 and x4 nonzero, flush=1 → both busy 0 next cycle; a pending write to x3 still appears on the RF port and its counter stays 0.
